// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous single-port RAM between a CPU (port 0)
// and a program loader (port 1), with round-robin tie-break and a burst cap.
module ram_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        ready_q;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        acc0, acc1, access, burst_done;
  logic [7:0]  cnt_inc;

  always_comb begin
    acc0       = (state_q == OWN0) && req0;
    acc1       = (state_q == OWN1) && req1;
    access     = acc0 || acc1;
    cnt_inc    = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 8'd1;
    // The access that fills the burst is the owner's last one when the other side waits.
    burst_done = access && (cnt_inc == BURST_MAX);

    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;

    case (state_q)
      IDLE: begin
        if (ready_q) begin
          if (req0 && (!req1 || last_owner_q)) state_d = OWN0;
          else if (req1)                       state_d = OWN1;
        end
      end
      OWN0: begin
        if (!req0)                     state_d = req1 ? OWN1 : IDLE;
        else if (burst_done && req1)   state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                     state_d = req0 ? OWN0 : IDLE;
        else if (burst_done && req0)   state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      burst_cnt_d = 8'd0;
      if (state_d == OWN0)      last_owner_d = 1'b0;
      else if (state_d == OWN1) last_owner_d = 1'b1;
    end else if (access) begin
      burst_cnt_d = cnt_inc;
    end

    rvalid0_d = acc0 && !we0;
    rvalid1_d = acc1 && !we1;
  end

  // ready_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      ready_q      <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      ready_q      <= 1'b1;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign ram_we    = acc0 ? we0    : (acc1 ? we1    : 1'b0);
  assign ram_addr  = acc0 ? addr0  : (acc1 ? addr1  : 16'h0000);
  assign ram_wdata = acc0 ? wdata0 : (acc1 ? wdata1 : 16'h0000);
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rvalid0_q ? ram_rdata : 16'h0000;
  assign rdata1    = rvalid1_q ? ram_rdata : 16'h0000;

endmodule
